// File: rtl/run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl_if
//  Description : Host / processor-facing signal bundle of the run controller.
//                The master side (host plus processor top level) drives the
//                requests; the slave side (run_ctrl) drives start and results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface run_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             go;
    logic             done;
    logic             result_ack;
    logic             start;
    logic             busy;
    logic             result_valid;
    logic [CNT_W-1:0] cycles;
    logic             timed_out;
    logic [7:0]       runs;

    modport master (
        output go, done, result_ack,
        input  start, busy, result_valid, cycles, timed_out, runs
    );

    modport slave (
        input  go, done, result_ack,
        output start, busy, result_valid, cycles, timed_out, runs
    );
endinterface

`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl
//  Description : Run controller in front of the processor top level. On a go
//                request it holds the core in reset for SETTLE cycles, lets it
//                run until done or TIMEOUT, then freezes it and offers the
//                cycle count / timeout flag to the host under valid/ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4000,
    parameter int SETTLE  = 2
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    run_ctrl_if.slave   bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RESET = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_HOLD  = 2'd3;

    localparam int               c_SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_SET_W-1:0] c_SETTLE_LD = c_SET_W'(SETTLE - 1);
    // One bit wider than the counter so count+1 can never alias TIMEOUT.
    localparam logic [CNT_W:0]   c_TIMEOUT_EXT = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_TIMEOUT_CNT = CNT_W'(TIMEOUT);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_SET_W-1:0] r_settle;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W:0]     w_count_inc;
    logic               w_hit_to;

    logic               r_start;
    logic               r_busy;
    logic               r_result_valid;
    logic [CNT_W-1:0]   r_cycles;
    logic               r_timed_out;
    logic [7:0]         r_runs;

    logic               w_start_nxt;
    logic               w_busy_nxt;
    logic               w_result_valid_nxt;

    assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    assign w_hit_to    = (w_count_inc == c_TIMEOUT_EXT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; go, done and ack only matter in their own state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.go)                w_state_nxt = c_ST_RESET;
            c_ST_RESET: if (r_settle == '0)        w_state_nxt = c_ST_RUN;
            c_ST_RUN:   if (bus.done || w_hit_to)  w_state_nxt = c_ST_HOLD;
            c_ST_HOLD:  if (bus.result_ack)        w_state_nxt = c_ST_IDLE;
            default:                               w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state.
    always_comb begin
        w_start_nxt        = (w_state_nxt == c_ST_RUN);
        w_busy_nxt         = (w_state_nxt == c_ST_RESET) || (w_state_nxt == c_ST_RUN);
        w_result_valid_nxt = (w_state_nxt == c_ST_HOLD);
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start        <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_start        <= w_start_nxt;
            r_busy         <= w_busy_nxt;
            r_result_valid <= w_result_valid_nxt;
        end
    end

    // Settle/cycle counters and the result registers presented to the host.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle    <= '0;
            r_count     <= '0;
            r_cycles    <= '0;
            r_timed_out <= 1'b0;
            r_runs      <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.go) begin
                        r_settle    <= c_SETTLE_LD;
                        r_cycles    <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                c_ST_RESET: begin
                    r_count <= '0;
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (bus.done) begin
                        r_cycles    <= r_count;
                        r_timed_out <= 1'b0;
                    end else if (w_hit_to) begin
                        r_cycles    <= c_TIMEOUT_CNT;
                        r_timed_out <= 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_ST_HOLD: begin
                    if (bus.result_ack) begin
                        r_runs <= r_runs + 8'd1;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.start        = r_start;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_result_valid;
    assign bus.cycles       = r_cycles;
    assign bus.timed_out    = r_timed_out;
    assign bus.runs         = r_runs;

endmodule

`default_nettype wire

// File: doc/run_ctrl.md
# run_ctrl

Run controller sitting directly upstream of the processor top level: it owns the top level's `start` input and watches its `done` output. On a host `go` pulse it holds the core in reset for a settle period, releases it, counts execution cycles until `done` or a timeout, then drops `start` to freeze the core in reset. It presents the cycle count and timeout flag to the host under a valid/ack handshake. Data memory is not reset by `start`, so results stay readable after the run.

## Interface
- `CNT_W`, 16: width of cycle counter; 1 <= `TIMEOUT` <= 2^CNT_W - 1.
- `TIMEOUT`, 4000: max RUN cycles with `done` low before abort.
- `SETTLE`, 2: cycles `start` is held low in RESET, >= 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `go`  in  1  host request, sampled only in IDLE.
- `done`  in  1  from processor top level; high when its PC reaches the end address.
- `result_ack`  in  1  host accepts result, sampled only in HOLD.
- `start`  out  1  to processor top level; 0 holds core in reset.
- `busy`  out  1  high in RESET and RUN.
- `result_valid`  out  1  high in HOLD.
- `cycles`  out  CNT_W  cycle count of last run.
- `timed_out`  out  1  last run ended by timeout.
- `runs`  out  8  completed-run counter, wraps 255 -> 0.

## Operation
- States: IDLE, RESET, RUN, HOLD. All outputs registered.
- IDLE: `start`=0. `go`=1 -> RESET; settle counter loaded with SETTLE-1; `cycles`, `timed_out` cleared.
- RESET: `start`=0, `busy`=1. Settle counter decrements; at 0 -> RUN. Internal count cleared.
- RUN: `start`=1, `busy`=1. Each cycle:
  - `done`=1 -> HOLD; `cycles` <= internal count; `timed_out`=0.
  - else if count+1 == TIMEOUT -> HOLD; `cycles` <= TIMEOUT; `timed_out`=1.
  - else count <= count+1.
- HOLD: `start`=0, `result_valid`=1, `cycles`/`timed_out` stable. `result_ack`=1 -> IDLE; `runs` <= `runs`+1 (timeouts count too).
- `go` outside IDLE is ignored (not queued). `go` with `result_ack` in HOLD: ack taken, `go` dropped; host must re-pulse in IDLE.
- `done` outside RUN is ignored.
- Count never wraps: TIMEOUT bound ensures exit first.

## Timing
- Reset values: state IDLE, `start`=0, `busy`=0, `result_valid`=0, `cycles`=0, `timed_out`=0, `runs`=0. Asserting `rst` in any state forces these immediately (asynchronously), dropping `start`; no result is produced for the aborted run.
- `go` high at edge N -> `busy`=1 after N; `start`=1 after edge N+SETTLE.
- `cycles` = number of RUN cycles in which `done` was sampled 0 (`done` in first RUN cycle -> 0).
- `done` sampled 1 at edge M -> after M: `start`=0, `result_valid`=1, `busy`=0.
- `result_ack` at edge K -> after K: `result_valid`=0, `runs` incremented, IDLE; `go` accepted at edge K+1 earliest.
- Back-to-back: minimum go-to-go spacing = SETTLE + RUN length + 2 cycles.

## Test plan
- Normal: defaults, `done` model rises after 190 RUN cycles -> `start` high for 191 cycles, `cycles`=190, `timed_out`=0, `result_valid` until ack, `runs`=1.
- Timeout: TIMEOUT=50, `done` held 0 -> HOLD after 50 RUN cycles, `cycles`=50, `timed_out`=1, `start`=0.
- Ignored requests: `go` pulsed during RESET, RUN, HOLD -> no restart, `cycles` unchanged; `done` pulse in IDLE -> no state change.
- Simultaneous `go` + `result_ack` in HOLD -> IDLE, `runs`+1, no new run until next `go`.
- Reset mid-RUN: `rst`=0 at RUN cycle 20 -> `start`, `busy`, `cycles`, `runs` go 0 immediately; after release, `go` -> clean run with correct count.
- Wrap: 256 acked runs with `done` after 3 cycles -> `runs` 255 -> 0, each `cycles`=3.
